// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for Wishbone master arbitration.
// Holds the arbiter FSM state encoding, bus widths and the round-robin pick.
// Pure declarations; no clocked logic lives here.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_t;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Largest requester count the helper supports; callers pad to this width.
  localparam int RR_MAX = 8;

  // One-hot grant for the first requester strictly after 'last', wrapping
  // modulo n. Returns all zeros when nobody requests.
  function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        last,
                                                input int                n);
    logic [RR_MAX-1:0] g;
    logic [2:0]        idx;
    g = '0;
    for (int i = 1; i <= RR_MAX; i++) begin
      if (i <= n) begin
        idx = 3'((int'(last) + i) % n);
        if (g == '0 && req[idx]) begin
          g[idx] = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_rr.sv
// Round-robin selector with a registered last-grantee pointer.
// Latency: grant output is combinational from req and the stored pointer.
// Backpressure: none; the owner loads the pointer when it releases the bus.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         update,
  input  logic [N-1:0] upd_grant,
  output logic [N-1:0] gnt
);

  logic [2:0]        ptr;
  logic [2:0]        upd_idx;
  logic [RR_MAX-1:0] req_pad;

  // Next grant: first requester after the last owner, modulo N.
  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    gnt            = N'(rr_next(req_pad, ptr, N));
  end

  // Convert the releasing owner's one-hot grant into a pointer value.
  always_comb begin
    upd_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (upd_grant[k]) begin
        upd_idx = 3'(k);
      end
    end
  end

  // Pointer starts at the highest index so master 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'(N - 1);
    end else if (update) begin
      ptr <= upd_idx;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Shares one Wishbone B3 master port among MASTERS local masters, round-robin per cycle.
// Latency: grant registers one cycle after cyc rises; bus signals are then a combinational mux.
// Backpressure: grant is held until the owner drops cyc; a watchdog errors out a hung slave.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MASTERS   = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_sys,
  input  logic [WB_ADR_W*MASTERS-1:0]    m_adr_i,
  input  logic [WB_DAT_W*MASTERS-1:0]    m_dat_i,
  input  logic [WB_SEL_W*MASTERS-1:0]    m_sel_i,
  input  logic [3*MASTERS-1:0]           m_cti_i,
  input  logic [2*MASTERS-1:0]           m_bte_i,
  input  logic [MASTERS-1:0]             m_cyc_i,
  input  logic [MASTERS-1:0]             m_stb_i,
  input  logic [MASTERS-1:0]             m_we_i,
  output logic [WB_DAT_W*MASTERS-1:0]    m_dat_o,
  output logic [MASTERS-1:0]             m_ack_o,
  output logic [MASTERS-1:0]             m_err_o,
  output logic [MASTERS-1:0]             m_rty_o,
  output logic [WB_ADR_W-1:0]            s_adr_o,
  output logic [WB_DAT_W-1:0]            s_dat_o,
  output logic [WB_SEL_W-1:0]            s_sel_o,
  output logic [2:0]                     s_cti_o,
  output logic [1:0]                     s_bte_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  input  logic [WB_DAT_W-1:0]            s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  input  logic                           s_rty_i,
  output logic [MASTERS-1:0]             grant_o,
  output logic                           timeout_o
);

  arb_state_t            state, state_nxt;
  logic [MASTERS-1:0]    grant;
  logic [MASTERS-1:0]    arb_gnt;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  g_cyc, g_stb, g_we;
  logic [WB_ADR_W-1:0]   g_adr;
  logic [WB_DAT_W-1:0]   g_dat;
  logic [WB_SEL_W-1:0]   g_sel;
  logic [2:0]            g_cti;
  logic [1:0]            g_bte;

  logic                  busy;
  logic                  term;
  logic                  stb_act;
  logic                  fire;
  logic                  release_own;
  logic                  route;

  wb_rr_arbiter #(
    .N (MASTERS)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_sys),
    .req       (m_cyc_i),
    .update    (release_own),
    .upd_grant (grant),
    .gnt       (arb_gnt)
  );

  // Select the granted master's request signals; all zero when nobody owns.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (grant[k]) begin
        g_cyc = g_cyc | m_cyc_i[k];
        g_stb = g_stb | m_stb_i[k];
        g_we  = g_we  | m_we_i[k];
        g_adr = g_adr | m_adr_i[WB_ADR_W*k +: WB_ADR_W];
        g_dat = g_dat | m_dat_i[WB_DAT_W*k +: WB_DAT_W];
        g_sel = g_sel | m_sel_i[WB_SEL_W*k +: WB_SEL_W];
        g_cti = g_cti | m_cti_i[3*k +: 3];
        g_bte = g_bte | m_bte_i[2*k +: 2];
      end
    end
  end

  // Ownership, watchdog and termination qualifiers.
  always_comb begin
    busy        = (state == BUSY);
    term        = s_ack_i | s_err_i | s_rty_i;
    stb_act     = busy & g_cyc & g_stb;
    // A real termination in the expiry cycle takes priority over the watchdog.
    fire        = (TIMEOUT != 0) && stb_act && !term &&
                  (cnt == CNT_WIDTH'(TIMEOUT));
    release_own = (state != IDLE) && !g_cyc;
    route       = busy & g_cyc;
  end

  // Bus-side outputs follow the owner only while BUSY and not timing out.
  always_comb begin
    s_cyc_o   = route & ~fire;
    s_stb_o   = stb_act & ~fire;
    s_we_o    = route & ~fire & g_we;
    s_adr_o   = busy ? g_adr : '0;
    s_dat_o   = busy ? g_dat : '0;
    s_sel_o   = busy ? g_sel : '0;
    s_cti_o   = busy ? g_cti : '0;
    s_bte_o   = busy ? g_bte : '0;
    m_dat_o   = busy ? {MASTERS{s_dat_i}} : '0;
    m_ack_o   = route ? (grant & {MASTERS{s_ack_i}})        : '0;
    m_err_o   = route ? (grant & {MASTERS{s_err_i | fire}}) : '0;
    m_rty_o   = route ? (grant & {MASTERS{s_rty_i}})        : '0;
    timeout_o = fire;
    grant_o   = grant;
  end

  // Next-state: arbitrate in IDLE, leave ownership when the owner drops cyc.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|m_cyc_i) state_nxt = BUSY;
      BUSY: begin
        if (!g_cyc) begin
          state_nxt = IDLE;
        end else if (fire) begin
          state_nxt = ERR;
        end
      end
      ERR:  if (!g_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant register: load the round-robin pick in IDLE, clear on release.
  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      grant <= '0;
    end else if (state == IDLE && |m_cyc_i) begin
      grant <= arb_gnt;
    end else if (release_own) begin
      grant <= '0;
    end
  end

  // Watchdog counter: counts unanswered strobe cycles and saturates.
  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      cnt <= '0;
    end else if (TIMEOUT == 0 || !stb_act || term || fire) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
